tlul_host_adapter: RTL

TL-UL initiator driving the outward (host) end of the 32-bit TL-UL register interface (TL_UL_4_32_2_8_8) that datapath blocks expose as responders. Converts a simple valid/ready read/write command stream into A-channel Get/PutFullData/PutPartialData beats. Tracks outstanding transactions by source ID and returns D-channel responses to the client in arrival order. Sits between a CSR/config sequencer and any block with an inward regs port.

---
 rtl/tlul_pkg.sv | 40 ++++
 rtl/tlul_if.sv | 49 ++++
 rtl/tlul_source_alloc.sv | 72 +++++++
 rtl/tlul_host_adapter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/tlul_pkg.sv
// ============================================================================
// Module      : tlul_pkg
// Description : Shared TL-UL opcodes, field widths and A-opcode helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tlul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_DBW = 4;
    localparam int TL_SZW = 2;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 8;

    typedef enum logic [2:0] {
        A_PUT_FULL    = 3'd0,
        A_PUT_PARTIAL = 3'd1,
        A_GET         = 3'd4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        D_ACCESS_ACK      = 3'd0,
        D_ACCESS_ACK_DATA = 3'd1
    } tl_d_op_e;

    // A zero mask still goes out as a partial put so the responder sees no lanes.
    function automatic logic [2:0] a_opcode_for(input logic write, input logic [TL_DBW-1:0] mask);
        if (!write) begin
            return A_GET;
        end else if (mask == 4'hF) begin
            return A_PUT_FULL;
        end
        return A_PUT_PARTIAL;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tlul_if.sv
// ============================================================================
// Module      : TL_UL_4_32_2_8_8
// Description : 32-bit TL-UL link; outward = host end, inward = responder end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface TL_UL_4_32_2_8_8;
    import tlul_pkg::*;

    logic              a_valid;
    logic              a_ready;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              a_corrupt;

    logic              d_valid;
    logic              d_ready;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic              d_denied;
    logic [TL_DW-1:0]  d_data;
    logic              d_corrupt;

    modport outward (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        output d_ready
    );

    modport inward (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        input  d_ready
    );

endinterface

`default_nettype wire

// File: rtl/tlul_source_alloc.sv
// ============================================================================
// Module      : tlul_source_alloc
// Description : Source-ID slot table: free bitmap, lowest-free encoder, write flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlul_source_alloc #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int IDX_W           = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             alloc,
    input  logic             alloc_write,
    output logic [IDX_W-1:0] alloc_idx,
    output logic             any_free,
    output logic             any_busy,
    input  logic             dealloc,
    input  logic [IDX_W-1:0] dealloc_idx,
    input  logic [IDX_W-1:0] query_idx,
    output logic             query_busy,
    output logic             query_write
);

    logic [MAX_OUTSTANDING-1:0] r_free;
    logic [MAX_OUTSTANDING-1:0] r_write;

    always_comb begin
        alloc_idx = '0;
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            if (r_free[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
    end

    assign any_free = |r_free;
    assign any_busy = ~&r_free;

    // Out-of-range IDs match no slot and therefore read back as free.
    always_comb begin
        query_busy  = 1'b0;
        query_write = 1'b0;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (query_idx == IDX_W'(i)) begin
                query_busy  = !r_free[i];
                query_write = r_write[i];
            end
        end
    end

    // Frees land in the register, so a released ID is offered one cycle later.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_free  <= '1;
            r_write <= '0;
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (alloc && alloc_idx == IDX_W'(i)) begin
                    r_free[i]  <= 1'b0;
                    r_write[i] <= alloc_write;
                end else if (dealloc && dealloc_idx == IDX_W'(i)) begin
                    r_free[i] <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tlul_host_adapter.sv
// ============================================================================
// Module      : tlul_host_adapter
// Description : Valid/ready command stream to TL-UL host; optional watchdog
//               enabled by TLUL_HOST_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlul_host_adapter
    import tlul_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [TL_AW-1:0]     req_addr,
    input  logic [TL_DW-1:0]     req_wdata,
    input  logic [TL_DBW-1:0]    req_mask,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [TL_DW-1:0]     rsp_rdata,
    output logic                 rsp_error,
    output logic                 rsp_write,
    output logic                 timeout,
    TL_UL_4_32_2_8_8.outward     bus
);

    logic              r_started;
    logic              r_a_valid;
    logic [2:0]        r_a_opcode;
    logic [TL_AIW-1:0] r_a_source;
    logic [TL_AW-1:0]  r_a_address;
    logic [TL_DBW-1:0] r_a_mask;
    logic [TL_DW-1:0]  r_a_data;
    logic              r_rsp_valid;
    logic [TL_DW-1:0]  r_rsp_rdata;
    logic              r_rsp_error;
    logic              r_rsp_write;

    logic              w_accept;
    logic              w_d_ready;
    logic              w_d_hs;
    logic [TL_AIW-1:0] w_alloc_idx;
    logic              w_any_free;
    logic              w_any_busy;
    logic              w_q_busy;
    logic              w_q_write;
    logic              w_is_data;
    logic              w_is_ack;
    logic              w_err;
    logic              w_unused_d;

    tlul_source_alloc #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .IDX_W           (TL_AIW)
    ) u_alloc (
        .clk         (clk),
        .rst_b       (rst_b),
        .alloc       (w_accept),
        .alloc_write (req_write),
        .alloc_idx   (w_alloc_idx),
        .any_free    (w_any_free),
        .any_busy    (w_any_busy),
        .dealloc     (w_d_hs && w_q_busy),
        .dealloc_idx (bus.d_source),
        .query_idx   (bus.d_source),
        .query_busy  (w_q_busy),
        .query_write (w_q_write)
    );

    // Holds off the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
        end
    end

    assign req_ready = r_started && (!r_a_valid || bus.a_ready) && w_any_free;
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_a_valid   <= 1'b0;
            r_a_opcode  <= '0;
            r_a_source  <= '0;
            r_a_address <= '0;
            r_a_mask    <= '0;
            r_a_data    <= '0;
        end else if (w_accept) begin
            r_a_valid   <= 1'b1;
            r_a_opcode  <= a_opcode_for(req_write, req_mask);
            r_a_source  <= w_alloc_idx;
            r_a_address <= {req_addr[TL_AW-1:2], 2'b00};
            r_a_mask    <= req_write ? req_mask : 4'hF;
            r_a_data    <= req_write ? req_wdata : '0;
        end else if (bus.a_ready) begin
            r_a_valid   <= 1'b0;
        end
    end

    assign bus.a_valid   = r_a_valid;
    assign bus.a_opcode  = r_a_opcode;
    assign bus.a_param   = 3'd0;
    assign bus.a_size    = r_a_valid ? TL_SZW'(2) : '0;
    assign bus.a_source  = r_a_source;
    assign bus.a_address = r_a_address;
    assign bus.a_mask    = r_a_mask;
    assign bus.a_data    = r_a_data;
    assign bus.a_corrupt = 1'b0;

    assign w_d_ready   = !r_rsp_valid || rsp_ready;
    assign bus.d_ready = w_d_ready;
    assign w_d_hs      = bus.d_valid && w_d_ready;

    assign w_is_data = (bus.d_opcode == D_ACCESS_ACK_DATA);
    assign w_is_ack  = (bus.d_opcode == D_ACCESS_ACK);
    assign w_err     = bus.d_denied
                     | (w_is_data && bus.d_corrupt)
                     | !w_q_busy
                     | (w_q_busy && w_q_write && w_is_data)
                     | (w_q_busy && !w_q_write && w_is_ack);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
            r_rsp_write <= 1'b0;
        end else if (w_d_hs) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_is_data ? bus.d_data : '0;
            r_rsp_error <= w_err;
            r_rsp_write <= w_q_write;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;
    assign rsp_write = r_rsp_write;

    assign w_unused_d = ^{bus.d_param, bus.d_size, bus.d_sink, req_addr[1:0]};

`ifdef TLUL_HOST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_timeout;

    // Saturates at the limit; the flag stays set until reset.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (w_d_hs || !w_any_busy) begin
            r_wd_cnt  <= '0;
        end else begin
            if (r_wd_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
                r_wd_cnt <= r_wd_cnt + CNT_W'(1);
            end
            if (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    localparam int UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
    logic w_unused_busy;
    assign w_unused_busy = w_any_busy;
    assign timeout       = 1'b0;
`endif

endmodule

`default_nettype wire
